// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipe_stage block:
//   state_t  - occupancy state of the stage (EMPTY / ONE / FULL)
//   CNT_W    - width of the bubble-cycle counter
//   CNT_MAX  - saturation value of the bubble-cycle counter
//   sat_inc  - saturating increment used by the bubble counter
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Increment by one, sticking at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == CNT_MAX) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_hold_reg.sv
// -----------------------------------------------------------------------------
// pipe_hold_reg
// One storage slot of the pipe stage: a payload register plus a control
// register. The payload has no reset; the control field is cleared
// synchronously so a discarded entry can never leak stale control bits.
// Ports:
//   clk        in   clock
//   load       in   capture data/ctrl at the next rising edge
//   clr        in   clear the control field (wins over load)
//   data       in   payload to capture
//   ctrl       in   control to capture
//   held_data  out  stored payload
//   held_ctrl  out  stored control
// -----------------------------------------------------------------------------
module pipe_hold_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              load,
  input  logic              clr,
  input  logic [WIDTH-1:0]  data,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [WIDTH-1:0]  held_data,
  output logic [CTRL_W-1:0] held_ctrl
);

  // Payload capture; no reset on the datapath.
  always_ff @(posedge clk) begin
    if (load) begin
      held_data <= data;
    end else begin
      held_data <= held_data;
    end
  end

  // Control capture with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      held_ctrl <= '0;
    end else if (load) begin
      held_ctrl <= ctrl;
    end else begin
      held_ctrl <= held_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// Valid/ready pipeline stage with stall, flush and a bubble counter.
// SKID=1: two entries (main + skid), ready_o does not depend on ready_i.
// SKID=0: single entry, ready_o = ~stall_i & (~valid_o | ready_i).
// Ports:
//   clk_i         in   clock
//   rst_i         in   synchronous active-high reset
//   valid_i       in   upstream presents an entry
//   ready_o       out  stage accepts an entry this cycle
//   data_i        in   upstream payload
//   ctrl_i        in   upstream control
//   stall_i       in   freeze the stage
//   flush_i       in   discard all held entries
//   valid_o       out  head entry valid
//   ready_i       in   downstream consumes the head entry
//   data_o        out  head payload
//   ctrl_o        out  head control, zero when valid_o=0
//   bubble_cnt_o  out  saturating count of cycles with valid_o=0
// -----------------------------------------------------------------------------
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  state_t            state;
  state_t            state_nxt;
  logic              acc;
  logic              rel;
  logic              main_load;
  logic              main_from_skid;
  logic              skid_load;
  logic              clr;
  logic [WIDTH-1:0]  main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [WIDTH-1:0]  main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [WIDTH-1:0]  skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  assign valid_o = (state == ONE) || (state == FULL);

  // Accept side: only registered state, stall and reset feed ready_o.
  // In skid mode ready_i is deliberately left out to break the ready chain.
  always_comb begin
    ready_o = 1'b0;
    if (SKID != 0) begin
      ready_o = ~rst_i & ~stall_i & (state != FULL);
    end else begin
      ready_o = ~rst_i & ~stall_i & (~valid_o | ready_i);
    end
  end

  assign acc = valid_i & ready_o;
  assign rel = valid_o & ready_i & ~stall_i;
  assign clr = rst_i | flush_i;

  // Next-state and register-load decode; reset/flush beat stall beat flow.
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (clr) begin
      state_nxt = EMPTY;
    end else if (stall_i) begin
      state_nxt = state;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state_nxt = ONE;
            main_load = 1'b1;
          end else begin
            state_nxt = EMPTY;
          end
        end
        ONE: begin
          if (acc && rel) begin
            state_nxt = ONE;
            main_load = 1'b1;
          end else if (acc) begin
            // Only reachable in skid mode: park the newcomer behind the head.
            if (SKID != 0) begin
              state_nxt = FULL;
              skid_load = 1'b1;
            end else begin
              state_nxt = ONE;
            end
          end else if (rel) begin
            state_nxt = EMPTY;
          end else begin
            state_nxt = ONE;
          end
        end
        FULL: begin
          if (rel) begin
            state_nxt      = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end else begin
            state_nxt = FULL;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Main register refills from the skid slot when draining FULL, else from input.
  always_comb begin
    if (main_from_skid) begin
      main_d_data = skid_data;
      main_d_ctrl = skid_ctrl;
    end else begin
      main_d_data = data_i;
      main_d_ctrl = ctrl_i;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Bubble counter: counts edges on which no valid head was presented.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt <= '0;
    end else if (!valid_o) begin
      bubble_cnt <= sat_inc(bubble_cnt);
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end

  assign bubble_cnt_o = bubble_cnt;

  pipe_hold_reg #(
    .WIDTH  (WIDTH),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk       (clk_i),
    .load      (main_load),
    .clr       (clr),
    .data      (main_d_data),
    .ctrl      (main_d_ctrl),
    .held_data (main_data),
    .held_ctrl (main_ctrl)
  );

  pipe_hold_reg #(
    .WIDTH  (WIDTH),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk       (clk_i),
    .load      (skid_load),
    .clr       (clr),
    .data      (data_i),
    .ctrl      (ctrl_i),
    .held_data (skid_data),
    .held_ctrl (skid_ctrl)
  );

  assign data_o = main_data;
  // Control is masked so a bubble never carries live control bits.
  assign ctrl_o = valid_o ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage
// Drives one SKID=1 and one SKID=0 instance with shared stimulus. Each has a
// FIFO scoreboard: entries are pushed when the model says the stage accepts
// and compared against the head output while the model holds them.
// -----------------------------------------------------------------------------
module tb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        vin;
  logic [63:0] din;
  logic [7:0]  cin;
  logic        stall;
  logic        flush;
  logic        rdy_in;

  logic        ready_a, valid_a, ready_b, valid_b;
  logic [63:0] data_a, data_b;
  logic [7:0]  ctrl_a, ctrl_b;
  logic [15:0] cnt_a, cnt_b;

  logic [71:0] qa[$];
  logic [71:0] qb[$];
  logic [15:0] cnta, cntb;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(64), .CTRL_W(8), .SKID(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(vin), .ready_o(ready_a),
    .data_i(din), .ctrl_i(cin), .stall_i(stall), .flush_i(flush),
    .valid_o(valid_a), .ready_i(rdy_in), .data_o(data_a), .ctrl_o(ctrl_a),
    .bubble_cnt_o(cnt_a)
  );

  pipe_stage #(.WIDTH(64), .CTRL_W(8), .SKID(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(vin), .ready_o(ready_b),
    .data_i(din), .ctrl_i(cin), .stall_i(stall), .flush_i(flush),
    .valid_o(valid_b), .ready_i(rdy_in), .data_o(data_b), .ctrl_o(ctrl_b),
    .bubble_cnt_o(cnt_b)
  );

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs against the models, advance the edge, update models.
  task automatic cycle();
    bit ea_rdy, eb_rdy, acc_a, rel_a, acc_b, rel_b, emp_a, emp_b;
    #1;
    emp_a  = (qa.size() == 0);
    emp_b  = (qb.size() == 0);
    ea_rdy = !rst && !stall && (qa.size() < 2);
    eb_rdy = !rst && !stall && (emp_b || rdy_in);

    chk("a_ready", 72'(ready_a), 72'(ea_rdy));
    chk("a_valid", 72'(valid_a), 72'(!emp_a));
    if (!emp_a) chk("a_head", {ctrl_a, data_a}, qa[0]);
    else        chk("a_ctrl_zero", 72'(ctrl_a), 72'd0);
    chk("a_bubble", 72'(cnt_a), 72'(cnta));

    chk("b_ready", 72'(ready_b), 72'(eb_rdy));
    chk("b_valid", 72'(valid_b), 72'(!emp_b));
    if (!emp_b) chk("b_head", {ctrl_b, data_b}, qb[0]);
    else        chk("b_ctrl_zero", 72'(ctrl_b), 72'd0);
    chk("b_bubble", 72'(cnt_b), 72'(cntb));

    acc_a = vin && ea_rdy;
    rel_a = !emp_a && rdy_in && !stall;
    acc_b = vin && eb_rdy;
    rel_b = !emp_b && rdy_in && !stall;

    @(posedge clk);

    if (rst) begin
      qa.delete(); qb.delete();
      cnta = 16'd0; cntb = 16'd0;
    end else begin
      if (emp_a && cnta != 16'hFFFF) cnta = cnta + 16'd1;
      if (emp_b && cntb != 16'hFFFF) cntb = cntb + 16'd1;
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (rel_a) void'(qa.pop_front());
        if (acc_a) qa.push_back({cin, din});
        if (rel_b) void'(qb.pop_front());
        if (acc_b) qb.push_back({cin, din});
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; vin = 1'b0; din = 64'd0; cin = 8'd0;
    stall = 1'b0; flush = 1'b0; rdy_in = 1'b0;
    cnta = 16'd0; cntb = 16'd0;

    // Bring both instances out of their unknown power-up state.
    @(posedge clk);
    @(posedge clk);
    #1;
    repeat (2) cycle();

    // Continuous streaming of 0xA5.
    rst = 1'b0; vin = 1'b1; din = 64'hA5; cin = 8'h3C; rdy_in = 1'b1;
    repeat (6) cycle();
    chk("stream_data", 72'(data_a), 72'h0A5);
    chk("stream_bubble", 72'(cnt_a), 72'd1);

    // Drain, then fill with 1, 2 under backpressure and release.
    vin = 1'b0; repeat (2) cycle();
    rdy_in = 1'b0; vin = 1'b1;
    din = 64'h1; cin = 8'h11; cycle();
    din = 64'h2; cin = 8'h22; cycle();
    vin = 1'b0; cycle();
    chk("full_ready", 72'(ready_a), 72'd0);
    rdy_in = 1'b1; repeat (3) cycle();

    // Stall with a held entry and a willing consumer.
    rdy_in = 1'b0; vin = 1'b1; din = 64'hDEAD_BEEF; cin = 8'h5A; cycle();
    vin = 1'b0; rdy_in = 1'b1; stall = 1'b1;
    repeat (3) cycle();
    chk("stall_data", 72'(data_a), 72'hDEAD_BEEF);
    stall = 1'b0; repeat (2) cycle();

    // Flush beats stall and an offered entry while FULL.
    rdy_in = 1'b0; vin = 1'b1;
    din = 64'h3; cin = 8'h33; cycle();
    din = 64'h4; cin = 8'h44; cycle();
    flush = 1'b1; stall = 1'b1; din = 64'h5; cin = 8'h55; cycle();
    flush = 1'b0; stall = 1'b0; vin = 1'b0; cycle();
    chk("flush_empty", 72'(valid_a), 72'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      vin    = 1'($urandom_range(0, 1));
      rdy_in = 1'($urandom_range(0, 1));
      stall  = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 15) == 0);
      din    = {$urandom, $urandom};
      cin    = 8'($urandom);
      cycle();
    end
    stall = 1'b0; flush = 1'b0;

    // Reset in the middle of a transfer with entries held.
    rdy_in = 1'b0; vin = 1'b1; din = 64'h77; cin = 8'h07; cycle();
    din = 64'h78; cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; vin = 1'b0; cycle();

    // Streaming again; the SKID=0 instance is checked alongside.
    vin = 1'b1; din = 64'hA5; cin = 8'h3C; rdy_in = 1'b1;
    repeat (6) cycle();
    chk("b_stream_data", 72'(data_b), 72'h0A5);

    // Long idle run to saturate the bubble counters.
    vin = 1'b0;
    repeat (70000) cycle();
    chk("a_saturated", 72'(cnt_a), 72'hFFFF);
    chk("b_saturated", 72'(cnt_b), 72'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
